// File: rtl/instr_decode_stage.sv
// Instruction register, one-hot decoder, flags register and fetch counter for the multicycle control FSM.
// Optional macro DECODE_REG_EN adds a pipeline register on the decoded bus and immediate (+1 cycle).
module instr_decode_stage #(
  parameter int IW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [IW-1:0]    instr_in,
  input  logic             ir_load,
  input  logic [3:0]       alu_flags,
  input  logic             flags_load,
  output logic [26:0]      opcode_out,
  output logic [7:0]       imm_out,
  output logic [3:0]       flags_reg,
  output logic             instr_valid,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [26:0] NOOP = 27'h0000001;

  logic [IW-1:0]    ir_q, ir_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [22:0]      dec_oh;
  logic [26:0]      dec_bus;

  always_comb begin
    ir_d    = ir_q;
    flags_d = flags_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (run && ir_load) begin
      ir_d    = instr_in;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (run && flags_load) flags_d = alu_flags;
  end

  always_comb begin
    dec_oh = '0;
    unique case (ir_q[15:12])
      4'h0: dec_oh[0]  = 1'b1;
      4'h1: begin
        unique case (ir_q[9:8])
          2'b00: dec_oh[1] = 1'b1;
          2'b01: dec_oh[2] = 1'b1;
          2'b10: dec_oh[3] = 1'b1;
          default: dec_oh[4] = 1'b1;
        endcase
      end
      4'h2: dec_oh[5]  = 1'b1;
      4'h3: dec_oh[6]  = 1'b1;
      4'h4: dec_oh[7]  = 1'b1;
      4'h5: dec_oh[8]  = 1'b1;
      4'h6: dec_oh[9]  = 1'b1;
      4'h7: dec_oh[10] = 1'b1;
      4'h8: dec_oh[11] = 1'b1;
      4'h9: dec_oh[12] = 1'b1;
      4'hA: dec_oh[13] = 1'b1;
      4'hB: dec_oh[14] = 1'b1;
      4'hC: begin
        if (ir_q[8]) dec_oh[16] = 1'b1;
        else         dec_oh[15] = 1'b1;
      end
      4'hD: dec_oh[17] = 1'b1;
      4'hE: dec_oh[18] = 1'b1;
      default: begin
        // Branch condition lives in the RX field.
        unique case (ir_q[11:10])
          2'b00: dec_oh[19] = 1'b1;
          2'b01: dec_oh[20] = 1'b1;
          2'b10: dec_oh[21] = 1'b1;
          default: dec_oh[22] = 1'b1;
        endcase
      end
    endcase
    dec_bus = valid_q ? {ir_q[11:10], ir_q[9:8], dec_oh} : NOOP;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q    <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ir_q    <= ir_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DECODE_REG_EN
  logic [26:0] dec_q, dec_d;
  logic [7:0]  imm_q, imm_d;

  always_comb begin
    dec_d = run ? dec_bus : dec_q;
    imm_d = run ? ir_q[7:0] : imm_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dec_q <= NOOP;
      imm_q <= '0;
    end else begin
      dec_q <= dec_d;
      imm_q <= imm_d;
    end
  end

  assign opcode_out = dec_q;
  assign imm_out    = imm_q;
`else
  assign opcode_out = dec_bus;
  assign imm_out    = ir_q[7:0];
`endif

  assign flags_reg   = flags_q;
  assign instr_valid = valid_q;
  assign instr_count = cnt_q;

endmodule
